aes_block_sequencer: RTL and testbench
======================================

Name: aes_block_sequencer

Overview:
- Upstream/downstream wrapper around the round-based AES controller and datapath.
- Accepts one plaintext/key pair over a valid/ready handshake. Starts the controller with its `go` strobe and streams the 16 plaintext and key bytes into the datapath during round 0.
- Maintains `round_num` by counting `en_round` pulses. Captures the 128-bit result on `done` and holds it on a valid/ready output handshake.
- Single-block buffering: a new block is accepted only after the previous result has been taken.

Parameters:
- NUM_ROUNDS, 10, final round number; `round_num` saturates here.
- BYTES_PER_BLOCK, 16, bytes streamed per block in FEED.
- WDOG_CYCLES, 400, watchdog limit in cycles from GO to `done` (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  sequencer can accept a block
- in_text  in  128  plaintext, byte 0 = bits [127:120]
- in_key  in  128  cipher key, same byte order
- go  out  1  active-low start strobe to the controller; idles high
- round_num  out  4  current round number to the controller
- en_round  in  1  one-cycle round-advance pulse from the controller
- done  in  1  one-cycle completion pulse from the controller
- text_byte  out  8  plaintext byte to the datapath
- key_byte  out  8  key byte to the datapath
- dp_out  in  128  datapath state, valid in the `done` cycle
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts the result
- out_text  out  128  ciphertext
- err  out  1  sticky watchdog error; tied 0 without the macro

Behaviour:
- Reset values (asynchronous): state=IDLE, go=1, round_num=0, text_byte=0, key_byte=0, out_valid=0, out_text=0, err=0, byte index=0.
- in_ready = (state==IDLE), combinational.
- State IDLE:
  - On in_valid&&in_ready: register in_text and in_key, clear round_num to 0, clear the watchdog, go to GO.
- State GO (1 cycle):
  - go=0 for exactly this cycle; next state FEED with byte index=0.
- State FEED (BYTES_PER_BLOCK cycles):
  - text_byte/key_byte = registered byte[idx]. These are registered outputs, valid in the cycle idx is presented.
  - idx increments each cycle. After idx==15, go to RUN; text_byte and key_byte return to 0.
- State RUN:
  - Each en_round pulse increments round_num, saturating at NUM_ROUNDS.
  - en_round is also honoured during FEED.
  - On done: out_text <= dp_out, out_valid <= 1 from the next cycle, go to OUT.
  - done while round_num != NUM_ROUNDS still captures.
- State OUT:
  - out_valid=1 and out_text stable until out_ready. On the handshake: out_valid <= 0, go to IDLE.
  - in_ready is not asserted in the same cycle, so the earliest next accept is one cycle later.
- Latency:
  - Accept to go low: 1 cycle.
  - go to first byte: 1 cycle.
  - done to out_valid: 1 cycle.
- Simultaneous events:
  - done and en_round in the same cycle: apply both; the increment saturates.
  - in_valid asserted in a non-IDLE state: ignored and held by the source.
- Spurious inputs:
  - done in IDLE or OUT is ignored.
  - en_round outside FEED/RUN is ignored.
- Reset mid-operation: immediate return to the reset values. The held block and result are discarded.

Optional Feature:
- Macro: AES_SEQ_WATCHDOG_EN
- Defined:
  - A cycle counter runs from GO.
  - If it reaches WDOG_CYCLES in FEED or RUN without done: set err=1 (sticky until reset), force go=1, drop to IDLE, discard the block.
- Undefined: no counter is present, err is tied 0, and RUN waits indefinitely.

Decomposition:
- Shared package aes_pkg:
  - State enum {IDLE, GO, FEED, RUN, OUT}.
  - AES_BLOCK_W=128, AES_BYTE_W=8, AES_NUM_ROUNDS=10.
  - Helper function get_byte(block, idx), returning block[127-8*idx -: 8].
- One natural sub-module: aes_seq_byte_mux, the registered byte selector for text and key indexed by idx.

Test Plan:
- Accept and feed:
  - Stimulus: in_text=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f.
  - Response: go low for 1 cycle; then text_byte sequence 00,11,…,ff and key_byte 00..0f over 16 consecutive cycles; in_ready low throughout.
- Round counting:
  - Stimulus: 10 en_round pulses, spaced 24 cycles apart, then 2 extra pulses.
  - Response: round_num steps 0→10 and stays at 10.
- Completion:
  - Stimulus: done with dp_out=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_valid=1 next cycle with that value; with out_ready low for 5 cycles, the value stays stable; the handshake returns to IDLE and in_ready rises 1 cycle later.
- Back-pressure on input:
  - Stimulus: in_valid held high while in RUN or OUT.
  - Response: no second accept; round_num unaffected; the block is accepted in the IDLE cycle after the result handshake.
- Reset mid-FEED:
  - Stimulus: reset asserted asynchronously at idx=7.
  - Response: all outputs return to reset values immediately, with no further bytes and no go.
- Watchdog (with AES_SEQ_WATCHDOG_EN, WDOG_CYCLES=50):
  - Stimulus: no done is ever driven.
  - Response: err=1 at cycle 50 after GO; return to IDLE; in_ready=1; err stays 1 until reset.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES block sequencer: state encoding,
// block/byte widths and the byte extractor used to stream a block.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        FEED = 3'd2,
        RUN  = 3'd3,
        OUT  = 3'd4
    } seq_state_t;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_BYTE_W     = 8;
    localparam int AES_NUM_ROUNDS = 10;

    // Byte 0 is the most significant byte; shifting by (15-idx) bytes brings it to the bottom.
    function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [AES_BLOCK_W-1:0] block,
                                                       input logic [3:0]             idx);
        logic [AES_BLOCK_W-1:0] shifted;
        shifted = block >> {~idx, 3'b000};
        return shifted[AES_BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/aes_seq_byte_mux.sv
// Registered byte selector: presents byte[i_idx] of the held text and key
// one cycle after i_load, and drives zero whenever no byte is being loaded.
module aes_seq_byte_mux
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [3:0]             i_idx,
    input  logic [AES_BLOCK_W-1:0] i_text,
    input  logic [AES_BLOCK_W-1:0] i_key,
    output logic [AES_BYTE_W-1:0]  o_text_byte,
    output logic [AES_BYTE_W-1:0]  o_key_byte
);

    // Byte output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_text_byte <= 8'd0;
            o_key_byte  <= 8'd0;
        end else if (i_load) begin
            o_text_byte <= get_byte(i_text, i_idx);
            o_key_byte  <= get_byte(i_key, i_idx);
        end else begin
            o_text_byte <= 8'd0;
            o_key_byte  <= 8'd0;
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Valid/ready wrapper around the round-based AES controller/datapath: accepts one
// block, strobes go, streams bytes, counts rounds and holds the result.
// Optional watchdog enabled by defining AES_SEQ_WATCHDOG_EN.
module aes_block_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS      = AES_NUM_ROUNDS,
    parameter int BYTES_PER_BLOCK = 16,
    parameter int WDOG_CYCLES     = 400
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_text,
    input  logic [AES_BLOCK_W-1:0] in_key,
    output logic                   go,
    output logic [3:0]             round_num,
    input  logic                   en_round,
    input  logic                   done,
    output logic [AES_BYTE_W-1:0]  text_byte,
    output logic [AES_BYTE_W-1:0]  key_byte,
    input  logic [AES_BLOCK_W-1:0] dp_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_text,
    output logic                   err
);

    localparam logic [3:0] LAST_IDX  = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [3:0] ROUND_MAX = 4'(NUM_ROUNDS);

    seq_state_t             r_state;
    logic                   r_go;
    logic [3:0]             r_round;
    logic [3:0]             r_idx;
    logic                   r_out_valid;
    logic [AES_BLOCK_W-1:0] r_out_text;
    logic [AES_BLOCK_W-1:0] r_text;
    logic [AES_BLOCK_W-1:0] r_key;

    logic       w_trip;
    logic       w_round_en;
    logic       w_load;
    logic [3:0] w_sel;

    assign in_ready   = (r_state == IDLE);
    assign go         = r_go;
    assign round_num  = r_round;
    assign out_valid  = r_out_valid;
    assign out_text   = r_out_text;
    assign w_round_en = en_round && ((r_state == FEED) || (r_state == RUN));

    // The mux registers the byte for the next cycle, so it runs one index ahead of r_idx.
    assign w_load = (r_state == GO) || ((r_state == FEED) && (r_idx != LAST_IDX) && !w_trip);
    assign w_sel  = (r_state == GO) ? 4'd0 : (r_idx + 4'd1);

`ifdef AES_SEQ_WATCHDOG_EN
    logic [15:0] r_wdog;
    logic        r_err;

    assign w_trip = ((r_state == FEED) || ((r_state == RUN) && !done)) &&
                    (r_wdog == 16'(WDOG_CYCLES - 1));
    assign err    = r_err;

    // Watchdog counter from GO and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= 16'd0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && in_valid) begin
                r_wdog <= 16'd0;
            end else if ((r_state == GO) || (r_state == FEED) || (r_state == RUN)) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= r_wdog;
            end
            if (w_trip) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end
`else
    assign w_trip = 1'b0;
    assign err    = 1'b0;
`endif

    // Sequencer FSM with registered go, round counter, byte index and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_go        <= 1'b1;
            r_round     <= 4'd0;
            r_idx       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_text  <= '0;
            r_text      <= '0;
            r_key       <= '0;
        end else begin
            r_go <= 1'b1;
            if (w_round_en && (r_round != ROUND_MAX)) begin
                r_round <= r_round + 4'd1;
            end
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_text  <= in_text;
                        r_key   <= in_key;
                        r_round <= 4'd0;
                        r_go    <= 1'b0;
                        r_state <= GO;
                    end
                end
                GO: begin
                    r_idx   <= 4'd0;
                    r_state <= FEED;
                end
                FEED: begin
                    if (w_trip) begin
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (done) begin
                        r_out_text  <= dp_out;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else if (w_trip) begin
                        r_state <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    aes_seq_byte_mux u_byte_mux (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_idx       (w_sel),
        .i_text      (r_text),
        .i_key       (r_key),
        .o_text_byte (text_byte),
        .o_key_byte  (key_byte)
    );

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: table of blocks run end to end
// with byte/result scoreboards, plus reset-mid-feed and watchdog sequences.
module tb_aes_block_sequencer;

`ifdef AES_SEQ_WATCHDOG_EN
    localparam int TB_WDOG = 50;
    localparam int SPACING = 2;
`else
    localparam int TB_WDOG = 400;
    localparam int SPACING = 24;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         go;
    logic [3:0]   round_num;
    logic         en_round;
    logic         done;
    logic [7:0]   text_byte;
    logic [7:0]   key_byte;
    logic [127:0] dp_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         err;

    int total = 0;
    int bad   = 0;

    logic [15:0]  byte_q[$];
    logic [127:0] res_q[$];

    typedef struct {
        logic [127:0] text;
        logic [127:0] key;
        logic [127:0] dp;
        int           npulses;
        bit           done_with_pulse;
        bit           hold_next;
    } vec_t;

    vec_t vecs[3];

    aes_block_sequencer #(
        .NUM_ROUNDS      (10),
        .BYTES_PER_BLOCK (16),
        .WDOG_CYCLES     (TB_WDOG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .go        (go),
        .round_num (round_num),
        .en_round  (en_round),
        .done      (done),
        .text_byte (text_byte),
        .key_byte  (key_byte),
        .dp_out    (dp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int sat_round(input int n);
        return (n > 10) ? 10 : n;
    endfunction

    // Offers a block at an IDLE negedge, checks the GO cycle, returns at FEED idx 0.
    task automatic start_block(input logic [127:0] t, input logic [127:0] k);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_text  = t;
        in_key   = k;
        for (int j = 0; j < 16; j++) begin
            byte_q.push_back({t[127-8*j -: 8], k[127-8*j -: 8]});
        end
        @(negedge clk);
        chk("go_low", go, 0);
        chk("in_ready_go", in_ready, 0);
        chk("round_cleared", round_num, 0);
    endtask

    task automatic feed_check(input int nbytes);
        logic [15:0] e;
        for (int j = 0; j < nbytes; j++) begin
            e = byte_q.pop_front();
            chk("text_byte", text_byte, e[15:8]);
            chk("key_byte", key_byte, e[7:0]);
            chk("go_high_feed", go, 1);
            chk("in_ready_feed", in_ready, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t v;
        int   exp_round;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12, 1'b0, 1'b1};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 10, 1'b0, 1'b0};
        vecs[2] = '{128'hfedcba9876543210f0e1d2c3b4a59687, 128'h5a5aa5a5c3c33c3c0ff0f00f12345678,
                    128'hdeadbeefcafef00d0123456789abcdef, 3, 1'b1, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_text   = 128'd0;
        in_key    = 128'd0;
        en_round  = 1'b0;
        done      = 1'b0;
        dp_out    = 128'd0;
        out_ready = 1'b0;

        @(negedge clk);
        chk("rst_go", go, 1);
        chk("rst_round", round_num, 0);
        chk("rst_text_byte", text_byte, 0);
        chk("rst_key_byte", key_byte, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_text", out_text, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // Spurious done/en_round in IDLE must be ignored
        done     = 1'b1;
        en_round = 1'b1;
        dp_out   = 128'h1;
        @(negedge clk);
        done     = 1'b0;
        en_round = 1'b0;
        chk("idle_done_ignored", out_valid, 0);
        chk("idle_en_ignored", round_num, 0);
        chk("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 3; i++) begin
            v = vecs[i];
            start_block(v.text, v.key);
            if (v.hold_next && (i + 1 < 3)) begin
                in_text = vecs[i+1].text;
                in_key  = vecs[i+1].key;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            feed_check(16);
            chk("bytes_zero_run", {text_byte, key_byte}, 0);
            for (int p = 0; p < v.npulses; p++) begin
                en_round = 1'b1;
                @(negedge clk);
                en_round = 1'b0;
                chk("round_step", round_num, sat_round(p + 1));
                chk("no_second_accept", in_ready, 0);
                repeat (SPACING - 1) @(negedge clk);
            end
            done     = 1'b1;
            en_round = v.done_with_pulse;
            dp_out   = v.dp;
            res_q.push_back(v.dp);
            exp_round = sat_round(v.npulses + (v.done_with_pulse ? 1 : 0));
            @(negedge clk);
            done     = 1'b0;
            en_round = 1'b0;
            dp_out   = ~v.dp;
            chk("out_valid_rise", out_valid, 1);
            chk("out_text", out_text, res_q[0]);
            chk("round_at_done", round_num, exp_round);
            repeat (5) begin
                @(negedge clk);
                chk("out_valid_hold", out_valid, 1);
                chk("out_text_hold", out_text, res_q[0]);
                chk("in_ready_out", in_ready, 0);
            end
            // Spurious done in OUT must not overwrite the held result
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            chk("out_done_ignored", out_text, res_q[0]);
            out_ready = 1'b1;
            chk("in_ready_handshake", in_ready, 0);
            @(negedge clk);
            out_ready = 1'b0;
            chk("out_valid_drop", out_valid, 0);
            chk("in_ready_after", in_ready, 1);
            void'(res_q.pop_front());
        end

        // Asynchronous reset while byte 7 is on the bus
        start_block(vecs[1].text, vecs[1].key);
        in_valid = 1'b0;
        @(negedge clk);
        feed_check(7);
        chk("byte7_before_reset", text_byte, vecs[1].text[71:64]);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_text_byte", text_byte, 0);
        chk("mid_rst_key_byte", key_byte, 0);
        chk("mid_rst_go", go, 1);
        chk("mid_rst_out_text", out_text, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        byte_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_go", go, 1);
            chk("rst_hold_bytes", {text_byte, key_byte}, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_go", go, 1);
        chk("post_rst_bytes", {text_byte, key_byte}, 0);

`ifdef AES_SEQ_WATCHDOG_EN
        start_block(vecs[0].text, vecs[0].key);
        in_valid = 1'b0;
        byte_q.delete();
        repeat (TB_WDOG - 1) @(negedge clk);
        chk("wdog_not_yet", err, 0);
        @(negedge clk);
        chk("wdog_err", err, 1);
        chk("wdog_idle", in_ready, 1);
        chk("wdog_go", go, 1);
        repeat (4) @(negedge clk);
        chk("wdog_sticky", err, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("wdog_cleared", err, 0);
`else
        chk("err_tied", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
